// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Holds the FSM state encoding, the largest supported requester count
// and the default starvation timeout.
package uart_tx_arbiter_pkg;

  // FSM encoding kept as plain constants so older tooling can read it.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Largest requester count the round-robin picker is sized for.
  localparam int MAX_REQ = 4;

  // Idle cycles a locked owner may withhold valid before losing the lock.
  localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches req starting one position after ptr, wrapping modulo NUM_REQ,
// and returns the first set bit as a one-hot winner.
//   req  : request vector
//   ptr  : index of the most recent winner (search starts at ptr+1)
//   win  : one-hot winner, zero when nothing requests
//   any  : at least one request bit is set
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic               any
);

  logic hit_s;

  // Walk the positions in priority order; the first requesting one wins.
  always_comb begin
    win   = '0;
    any   = 1'b0;
    hit_s = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        hit_s  = (j == ((int'(ptr) + k) % NUM_REQ)) && req[j] && !any;
        win[j] = win[j] | hit_s;
        any    = any | hit_s;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte-stream requesters.
// Round-robin arbitration with packet lock: the owner keeps the transmitter
// until it sends a byte flagged last, or until it withholds valid for
// TIMEOUT_CYCLES cycles. A single registered buffer drives the UART.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_data     : byte of requester i in bits [8i+7:8i]
//   req_valid    : requester i presents a byte
//   req_last     : byte of requester i closes its packet
//   req_ready    : byte of requester i is accepted this cycle
//   tx_data      : byte to the UART
//   tx_valid     : tx_data is valid
//   tx_ready     : UART accepts tx_data
//   grant        : one-hot current owner, zero while idle
//   busy         : a requester holds the lock
//   timeout_evt  : one-cycle pulse when a lock is revoked
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CTR_W          = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout_evt
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  logic [0:0]         state_r;
  logic [NUM_REQ-1:0] grant_r;
  logic [PTR_W-1:0]   ptr_r;
  logic [CTR_W-1:0]   ctr_r;
  logic [7:0]         tx_data_r;
  logic               tx_valid_r;
  logic               timeout_evt_r;

  logic               can_load_s;
  logic               owner_valid_s;
  logic               owner_last_s;
  logic [7:0]         owner_data_s;
  logic [PTR_W-1:0]   owner_idx_s;
  logic               beat_s;
  logic               revoke_s;
  logic [NUM_REQ-1:0] win_s;
  logic               any_s;

  uart_tx_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (ptr_r),
    .win (win_s),
    .any (any_s)
  );

  // Select the owner's byte, last flag and index; grant_r is one-hot so OR-ing is a mux.
  always_comb begin
    owner_data_s = 8'h00;
    owner_idx_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_data_s = owner_data_s | (req_data[8*i +: 8] & {8{grant_r[i]}});
      owner_idx_s  = owner_idx_s | (PTR_W'(i) & {PTR_W{grant_r[i]}});
    end
  end

  // Handshake terms; req_ready is deliberately combinational from tx_ready.
  always_comb begin
    can_load_s    = ~tx_valid_r | tx_ready;
    owner_valid_s = |(req_valid & grant_r);
    owner_last_s  = |(req_last & grant_r);
    req_ready     = (state_r == ST_LOCKED) ? (grant_r & {NUM_REQ{can_load_s}}) : '0;
    beat_s        = (state_r == ST_LOCKED) & owner_valid_s & can_load_s;
    // Only cycles where the owner withholds valid count toward revocation.
    revoke_s      = (TIMEOUT_CYCLES > 0) && (state_r == ST_LOCKED) && !owner_valid_s &&
                    (ctr_r == CTR_W'(TIMEOUT_CYCLES - 1));
  end

  // Arbitration FSM, round-robin pointer and starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      grant_r       <= '0;
      ptr_r         <= PTR_W'(NUM_REQ - 1);
      ctr_r         <= '0;
      timeout_evt_r <= 1'b0;
    end else begin
      timeout_evt_r <= revoke_s;
      case (state_r)
        ST_IDLE: begin
          ctr_r <= '0;
          if (any_s) begin
            grant_r <= win_s;
            state_r <= ST_LOCKED;
          end else begin
            grant_r <= '0;
            state_r <= ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if ((beat_s && owner_last_s) || revoke_s) begin
            // Ending the lock always leaves one IDLE bubble before the next grant.
            state_r <= ST_IDLE;
            grant_r <= '0;
            ptr_r   <= owner_idx_s;
            ctr_r   <= '0;
          end else if (owner_valid_s) begin
            // Beats and UART stalls both prove the owner is still alive.
            ctr_r <= '0;
          end else if (TIMEOUT_CYCLES > 0) begin
            ctr_r <= ctr_r + CTR_W'(1);
          end else begin
            ctr_r <= '0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          grant_r <= '0;
          ctr_r   <= '0;
        end
      endcase
    end
  end

  // Single-entry output buffer toward the UART.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
    end else if (beat_s) begin
      tx_data_r  <= owner_data_s;
      tx_valid_r <= 1'b1;
    end else if (tx_ready) begin
      tx_valid_r <= 1'b0;
    end else begin
      tx_valid_r <= tx_valid_r;
    end
  end

  assign tx_data     = tx_data_r;
  assign tx_valid    = tx_valid_r;
  assign grant       = grant_r;
  assign busy        = state_r[0];
  assign timeout_evt = timeout_evt_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [NR-1:0]   grant;
  logic            busy;
  logic            timeout_evt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int evt_count = 0;
  int beat_cyc [NR];

  logic [8:0]    src_q [NR][$];   // {last, data} per requester
  logic [NR-1:0] en = '0;
  logic [7:0]    exp_q [$];       // expected UART byte order
  logic [NR-1:0] exp_g [$];       // expected grant order

  uart_tx_arbiter #(
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (8),
    .CTR_W          (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_data    (req_data),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .grant       (grant),
    .busy        (busy),
    .timeout_evt (timeout_evt)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_src(input int i, input logic last, input logic [7:0] d);
    src_q[i].push_back({last, d});
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || exp_g.size() != 0 || grant != '0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < 300), 32'd1);
  endtask

  // Requester models: pop on accepted beats, present the next queued byte.
  initial begin
    logic [NR-1:0] acc;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (en[i] && src_q[i].size() > 0) begin
          req_valid[i]      = 1'b1;
          req_last[i]       = src_q[i][0][8];
          req_data[8*i +: 8] = src_q[i][0][7:0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Monitor: compares UART beats and new grants against the scoreboard queues.
  initial begin
    logic [NR-1:0] prev_g;
    logic [7:0]    e;
    logic [NR-1:0] eg;
    prev_g = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (tx_valid && tx_ready) begin
          checks = checks + 1;
          if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL tx_extra got %02h expected nothing", tx_data);
          end else begin
            e = exp_q.pop_front();
            if (tx_data !== e) begin
              errors = errors + 1;
              $display("FAIL tx_data got %02h expected %02h", tx_data, e);
            end
          end
        end
        if (grant != '0 && grant != prev_g) begin
          checks = checks + 1;
          if (exp_g.size() == 0) begin
            errors = errors + 1;
            $display("FAIL grant_extra got %b expected none", grant);
          end else begin
            eg = exp_g.pop_front();
            if (grant !== eg) begin
              errors = errors + 1;
              $display("FAIL grant_order got %b expected %b", grant, eg);
            end
          end
        end
        checks = checks + 1;
        if (((req_ready & ~grant) != '0) || (busy !== (grant != '0))) begin
          errors = errors + 1;
          $display("FAIL ready_owner got ready=%b busy=%b grant=%b", req_ready, busy, grant);
        end
        for (int i = 0; i < NR; i++) begin
          if (req_valid[i] && req_ready[i]) beat_cyc[i] = cyc + 1;
        end
        if (timeout_evt) evt_count = evt_count + 1;
      end
      prev_g = grant;
    end
  end

  initial begin
    int n;
    int evt_at;
    rst_n    = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout_evt", 32'(timeout_evt), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);

    // Two requesters always valid, two-byte packets: 0,1,0,1.
    push_src(0, 1'b0, 8'h10); push_src(0, 1'b1, 8'h11);
    push_src(0, 1'b0, 8'h12); push_src(0, 1'b1, 8'h13);
    push_src(1, 1'b0, 8'h20); push_src(1, 1'b1, 8'h21);
    push_src(1, 1'b0, 8'h22); push_src(1, 1'b1, 8'h23);
    exp_q.push_back(8'h10); exp_q.push_back(8'h11);
    exp_q.push_back(8'h20); exp_q.push_back(8'h21);
    exp_q.push_back(8'h12); exp_q.push_back(8'h13);
    exp_q.push_back(8'h22); exp_q.push_back(8'h23);
    exp_g.push_back(4'b0001); exp_g.push_back(4'b0010);
    exp_g.push_back(4'b0001); exp_g.push_back(4'b0010);
    @(posedge clk); #2 en = 4'b0011;
    @(posedge clk); #2;
    @(negedge clk);
    check("lat_c0_grant", 32'(grant), 32'd0);
    @(negedge clk);
    check("lat_c1_grant", 32'(grant), 32'b0001);
    check("lat_c1_ready", 32'(req_ready), 32'b0001);
    @(negedge clk);
    check("lat_c2_tx_valid", 32'(tx_valid), 32'd1);
    check("lat_c2_tx_data", 32'(tx_data), 32'h10);
    wait_drain("t1_drain");
    en = '0;

    // Packet lock: requester 1 arrives mid-packet, then sends two packets alone.
    push_src(0, 1'b0, 8'h41); push_src(0, 1'b0, 8'h42); push_src(0, 1'b1, 8'h43);
    push_src(1, 1'b0, 8'h61); push_src(1, 1'b1, 8'h62); push_src(1, 1'b1, 8'h63);
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h63);
    exp_g.push_back(4'b0001); exp_g.push_back(4'b0010); exp_g.push_back(4'b0010);
    @(posedge clk); #2 en = 4'b0001;
    n = 0;
    while (src_q[0].size() != 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t2_first_beat", 32'(n < 50), 32'd1);
    en[1] = 1'b1;
    wait_drain("t2_drain");
    en = '0;

    // UART stall longer than the timeout while the owner keeps valid high.
    push_src(0, 1'b0, 8'h55); push_src(0, 1'b1, 8'h56);
    exp_q.push_back(8'h55); exp_q.push_back(8'h56);
    exp_g.push_back(4'b0001);
    @(posedge clk); #2 tx_ready = 1'b0; en = 4'b0001;
    n = 0;
    while (!tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t3_load", 32'(n < 20), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t3_hold_valid", 32'(tx_valid), 32'd1);
      check("t3_hold_data", 32'(tx_data), 32'h55);
      check("t3_hold_ready", 32'(req_ready), 32'd0);
      check("t3_no_timeout", 32'(timeout_evt), 32'd0);
    end
    @(posedge clk); #2 tx_ready = 1'b1;
    wait_drain("t3_drain");
    check("t3_evt_count", 32'(evt_count), 32'd0);
    en = '0;

    // Starvation timeout: requester 1 sends one non-last byte and goes quiet.
    push_src(1, 1'b0, 8'h71);
    exp_q.push_back(8'h71); exp_q.push_back(8'h81);
    exp_g.push_back(4'b0010); exp_g.push_back(4'b0001);
    @(posedge clk); #2 en = 4'b0010;
    n = 0;
    while (src_q[1].size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t4_beat", 32'(n < 50), 32'd1);
    push_src(0, 1'b1, 8'h81);
    en = 4'b0011;
    n = 0;
    while (!timeout_evt && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t4_evt_seen", 32'(n < 40), 32'd1);
    evt_at = cyc;
    check("t4_evt_delay", 32'(evt_at - beat_cyc[1]), 32'd8);
    check("t4_evt_grant", 32'(grant), 32'd0);
    check("t4_evt_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("t4_evt_pulse", 32'(timeout_evt), 32'd0);
    check("t4_next_grant", 32'(grant), 32'b0001);
    wait_drain("t4_drain");
    check("t4_evt_count", 32'(evt_count), 32'd1);
    en = '0;

    // Reset mid-packet with a byte buffered.
    push_src(2, 1'b0, 8'h91); push_src(2, 1'b0, 8'h92); push_src(2, 1'b1, 8'h93);
    exp_g.push_back(4'b0100);
    @(posedge clk); #2 tx_ready = 1'b0; en = 4'b0100;
    n = 0;
    while (!tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_load", 32'(n < 20), 32'd1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("t6_async_tx_valid", 32'(tx_valid), 32'd0);
    check("t6_async_grant", 32'(grant), 32'd0);
    check("t6_async_busy", 32'(busy), 32'd0);
    en = '0;
    src_q[2].delete();
    @(posedge clk); #2 rst_n = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    check("t6_post_grant", 32'(grant), 32'd0);
    check("t6_post_tx_valid", 32'(tx_valid), 32'd0);

    // Four single-byte requesters: grant order 0,1,2,3,0 shows the pointer wrap.
    push_src(0, 1'b1, 8'hC0); push_src(0, 1'b1, 8'hC4);
    push_src(1, 1'b1, 8'hC1);
    push_src(2, 1'b1, 8'hC2);
    push_src(3, 1'b1, 8'hC3);
    exp_q.push_back(8'hC0); exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
    exp_q.push_back(8'hC3); exp_q.push_back(8'hC4);
    exp_g.push_back(4'b0001); exp_g.push_back(4'b0010); exp_g.push_back(4'b0100);
    exp_g.push_back(4'b1000); exp_g.push_back(4'b0001);
    @(posedge clk); #2 en = 4'b1111;
    wait_drain("t5_drain");
    en = '0;
    check("end_evt_count", 32'(evt_count), 32'd1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
